// File: rtl/program_loader.sv
// program_loader: turns a byte stream (16-bit big-endian word count, then
// big-endian 32-bit instruction words) into the CPU's instruction-initialize
// writes. The CPU is held in reset during the load and released afterwards
// so that it starts running from BASE_ADDR.
module program_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'd0,
    parameter int          MAX_WORDS   = 64,
    parameter int          HOLD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        initialize,
    output logic [31:0] instruction_initialize_data,
    output logic [31:0] instruction_initialize_address,
    output logic        load_we,
    output logic        cpu_rst,
    output logic        done,
    output logic        error
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LEN_HI  = 3'd1;
    localparam logic [2:0] S_LEN_LO  = 3'd2;
    localparam logic [2:0] S_WORD    = 3'd3;
    localparam logic [2:0] S_WRITE   = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;
    localparam logic [2:0] S_RUN     = 3'd6;
    localparam logic [2:0] S_ERR     = 3'd7;

    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

    // The release counter only has to reach HOLD_CYCLES-1; at least one bit wide.
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    logic [2:0]    state;
    logic [15:0]   word_count;
    logic [15:0]   idx;
    logic [1:0]    bc;
    logic [23:0]   shreg;
    logic [HW-1:0] hold_cnt;

    logic          xfer;
    logic [15:0]   len_next;
    logic [15:0]   idx_next;
    logic [31:0]   word_addr;

    assign xfer      = in_valid & in_ready;
    assign len_next  = {word_count[15:8], in_data};
    assign idx_next  = idx + 16'd1;
    assign word_addr = BASE_ADDR + {14'd0, idx, 2'b00};

    // Sequencer: header capture, big-endian word assembly, write strobe and release timing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                          <= S_IDLE;
            word_count                     <= 16'd0;
            idx                            <= 16'd0;
            bc                             <= 2'd0;
            shreg                          <= 24'd0;
            hold_cnt                       <= '0;
            instruction_initialize_data    <= 32'h0;
            instruction_initialize_address <= BASE_ADDR;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) state <= S_LEN_HI;
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        word_count[15:8] <= in_data;
                        state            <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        word_count <= len_next;
                        if (len_next == 16'd0 || len_next > MAX_N) begin
                            state <= S_ERR;
                        end else begin
                            idx   <= 16'd0;
                            bc    <= 2'd0;
                            state <= S_WORD;
                        end
                    end
                end
                S_WORD: begin
                    if (xfer) begin
                        shreg <= {shreg[15:0], in_data};
                        bc    <= bc + 2'd1;
                        if (bc == 2'd3) begin
                            instruction_initialize_data    <= {shreg, in_data};
                            instruction_initialize_address <= word_addr;
                            state                          <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    idx <= idx_next;
                    bc  <= 2'd0;
                    if (idx_next == word_count) begin
                        hold_cnt <= '0;
                        state    <= S_RELEASE;
                    end else begin
                        state <= S_WORD;
                    end
                end
                S_RELEASE: begin
                    if (hold_cnt == HOLD_LAST) state <= S_RUN;
                    else hold_cnt <= hold_cnt + HW'(1);
                end
                S_RUN: begin
                    if (start) state <= S_LEN_HI;
                end
                S_ERR: begin
                    if (start) state <= S_LEN_HI;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Control outputs are pure functions of the current state.
    always_comb begin
        in_ready   = 1'b0;
        initialize = 1'b0;
        load_we    = 1'b0;
        cpu_rst    = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            S_LEN_HI, S_LEN_LO, S_WORD: begin
                in_ready   = 1'b1;
                initialize = 1'b1;
            end
            S_WRITE: begin
                initialize = 1'b1;
                load_we    = 1'b1;
            end
            S_RUN: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
            end
            S_ERR: begin
                error = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed, table-driven bench for program_loader.
// A per-cycle table covers the nominal load; hand-written sequences cover
// stalls, length errors, ignored starts, reload from RUN and reset mid-word.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        initialize;
    logic [31:0] instruction_initialize_data;
    logic [31:0] instruction_initialize_address;
    logic        load_we;
    logic        cpu_rst;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        start;
        logic        valid;
        logic [7:0]  din;
        logic        ready;
        logic        init;
        logic        we;
        logic        crst;
        logic        dn;
        logic        err;
        logic [31:0] data;
        logic [31:0] addr;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    vec_t tbl[17];
    wr_t  wr_q[$];
    logic [7:0] nom_bytes[10];

    program_loader #(
        .BASE_ADDR(32'd0),
        .MAX_WORDS(64),
        .HOLD_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .initialize(initialize),
        .instruction_initialize_data(instruction_initialize_data),
        .instruction_initialize_address(instruction_initialize_address),
        .load_we(load_we),
        .cpu_rst(cpu_rst),
        .done(done),
        .error(error)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Record every write strobe seen by the CPU side, sampled mid-cycle.
    always @(negedge clk) begin
        if (load_we === 1'b1)
            wr_q.push_back('{addr: instruction_initialize_address, data: instruction_initialize_data});
    end

    // Hard stop in case something upstream of the bounded waits hangs.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
        check_output({tag, "_init"}, {31'd0, initialize}, 32'd0);
        check_output({tag, "_we"}, {31'd0, load_we}, 32'd0);
        check_output({tag, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd1);
        check_output({tag, "_done"}, {31'd0, done}, 32'd0);
        check_output({tag, "_error"}, {31'd0, error}, 32'd0);
        check_output({tag, "_data"}, instruction_initialize_data, 32'h0);
        check_output({tag, "_addr"}, instruction_initialize_address, 32'h0);
    endtask

    // Entered at posedge+1: drive one table row, check mid-cycle, step to next cycle.
    task automatic apply_stimulus(input int i, input vec_t v);
        string t;
        t = $sformatf("row%0d", i);
        start    = v.start;
        in_valid = v.valid;
        in_data  = v.din;
        #1;
        check_output({t, "_ready"}, {31'd0, in_ready}, {31'd0, v.ready});
        check_output({t, "_init"}, {31'd0, initialize}, {31'd0, v.init});
        check_output({t, "_we"}, {31'd0, load_we}, {31'd0, v.we});
        check_output({t, "_cpu_rst"}, {31'd0, cpu_rst}, {31'd0, v.crst});
        check_output({t, "_done"}, {31'd0, done}, {31'd0, v.dn});
        check_output({t, "_error"}, {31'd0, error}, {31'd0, v.err});
        check_output({t, "_data"}, instruction_initialize_data, v.data);
        check_output({t, "_addr"}, instruction_initialize_address, v.addr);
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offer one byte after 'gap' idle cycles and hold it until accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = b;
        waited   = 0;
        #1;
        while (in_ready !== 1'b1 && waited < 50) begin
            @(posedge clk); #2;
            waited++;
        end
        if (in_ready !== 1'b1) begin
            check_output("xfer_timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
        end else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_nominal(input int gap, input logic check_init);
        for (int i = 0; i < 10; i++) begin
            send_byte(nom_bytes[i], gap);
            if (check_init) check_output($sformatf("stall_init_b%0d", i), {31'd0, initialize}, 32'd1);
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check_output(name, {31'd0, done}, 32'd1);
    endtask

    task automatic expect_write(input string name, input logic [31:0] addr, input logic [31:0] data);
        wr_t w;
        if (wr_q.size() == 0) begin
            check_output({name, "_present"}, 32'd0, 32'd1);
        end else begin
            w = wr_q.pop_front();
            check_output({name, "_addr"}, w.addr, addr);
            check_output({name, "_data"}, w.data, data);
        end
    endtask

    task automatic expect_no_more_writes(input string name);
        check_output(name, wr_q.size(), 32'd0);
        wr_q.delete();
    endtask

    initial begin
        nom_bytes = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};

        //            st val din    rdy ini we  crst dn err  data          addr
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0};
        tbl[1]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0};
        tbl[2]  = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0};
        tbl[3]  = '{1'b0, 1'b1, 8'h20, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0};
        tbl[4]  = '{1'b0, 1'b1, 8'h08, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0};
        tbl[5]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0};
        tbl[6]  = '{1'b0, 1'b1, 8'h05, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0};
        tbl[7]  = '{1'b0, 1'b1, 8'h20, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h20080005, 32'h0};
        tbl[8]  = '{1'b0, 1'b1, 8'h20, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20080005, 32'h0};
        tbl[9]  = '{1'b0, 1'b1, 8'h09, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20080005, 32'h0};
        tbl[10] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20080005, 32'h0};
        tbl[11] = '{1'b0, 1'b1, 8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20080005, 32'h0};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h20090007, 32'h4};
        tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20090007, 32'h4};
        tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20090007, 32'h4};
        tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20090007, 32'h4};
        tbl[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20090007, 32'h4};

        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_reset_values("reset");
        @(posedge clk); #1;
        wr_q.delete();

        $display("[TB] nominal load, cycle by cycle");
        for (int i = 0; i < 17; i++) apply_stimulus(i, tbl[i]);
        start    = 1'b0;
        in_valid = 1'b0;
        expect_write("nom_w0", 32'h0, 32'h20080005);
        expect_write("nom_w1", 32'h4, 32'h20090007);
        expect_no_more_writes("nom_extra");

        $display("[TB] reload from RUN with a stalled stream");
        pulse_start();
        check_output("reload_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check_output("reload_done", {31'd0, done}, 32'd0);
        check_output("reload_init", {31'd0, initialize}, 32'd1);
        send_nominal(3, 1'b1);
        wait_done("stall_done", 20);
        expect_write("stall_w0", 32'h0, 32'h20080005);
        expect_write("stall_w1", 32'h4, 32'h20090007);
        expect_no_more_writes("stall_extra");

        $display("[TB] length errors");
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        #1;
        check_output("len0_error", {31'd0, error}, 32'd1);
        check_output("len0_init", {31'd0, initialize}, 32'd0);
        check_output("len0_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check_output("len0_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        pulse_start();
        check_output("err_clear", {31'd0, error}, 32'd0);
        send_byte(8'h00, 0);
        send_byte(8'h41, 0);
        #1;
        check_output("len65_error", {31'd0, error}, 32'd1);
        check_output("len65_init", {31'd0, initialize}, 32'd0);
        check_output("len65_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        expect_no_more_writes("len_err_writes");
        @(posedge clk); #1;
        pulse_start();
        send_nominal(0, 1'b0);
        wait_done("err_recover_done", 20);
        check_output("err_recover_error", {31'd0, error}, 32'd0);
        expect_write("err_w0", 32'h0, 32'h20080005);
        expect_write("err_w1", 32'h4, 32'h20090007);
        expect_no_more_writes("err_extra");

        $display("[TB] start ignored during WORD and WRITE");
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(nom_bytes[i], 0);
        pulse_start();
        check_output("ign_word_ready", {31'd0, in_ready}, 32'd1);
        send_byte(8'h00, 0);
        send_byte(8'h05, 0);
        start = 1'b1;
        #1;
        check_output("ign_write_we", {31'd0, load_we}, 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        check_output("ign_after_write_ready", {31'd0, in_ready}, 32'd1);
        check_output("ign_after_write_we", {31'd0, load_we}, 32'd0);
        for (int i = 6; i < 10; i++) send_byte(nom_bytes[i], 0);
        wait_done("ign_done", 20);
        expect_write("ign_w0", 32'h0, 32'h20080005);
        expect_write("ign_w1", 32'h4, 32'h20090007);
        expect_no_more_writes("ign_extra");

        $display("[TB] one-word reload");
        pulse_start();
        check_output("one_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h08, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        wait_done("one_done", 20);
        expect_write("one_w0", 32'h0, 32'h08000000);
        expect_no_more_writes("one_extra");

        $display("[TB] reset mid-word");
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_reset_values("midrst");
        expect_no_more_writes("midrst_writes");
        @(posedge clk); #1;
        check_output("midrst_idle_init", {31'd0, initialize}, 32'd0);
        pulse_start();
        send_nominal(0, 1'b0);
        wait_done("midrst_done", 20);
        expect_write("midrst_w0", 32'h0, 32'h20080005);
        expect_write("midrst_w1", 32'h4, 32'h20090007);
        expect_no_more_writes("midrst_extra");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
